// File: rtl/cutter_pkg.sv
// Shared definitions for the crop-window controller: register map, bit fields, FSM states.
package cutter_pkg;

  // Register addresses
  localparam logic [2:0] AddrCtrl   = 3'd0;
  localparam logic [2:0] AddrSx     = 3'd1;
  localparam logic [2:0] AddrSy     = 3'd2;
  localparam logic [2:0] AddrWidth  = 3'd3;
  localparam logic [2:0] AddrHeight = 3'd4;
  localparam logic [2:0] AddrStep   = 3'd5;
  localparam logic [2:0] AddrPeriod = 3'd6;
  localparam logic [2:0] AddrStatus = 3'd7;

  // CTRL bit positions
  localparam int unsigned CtrlEnBit      = 0;
  localparam int unsigned CtrlAutoPanBit = 1;
  localparam int unsigned CtrlCommitBit  = 2;

  // STATUS bit positions
  localparam int unsigned StatErrBit  = 0;
  localparam int unsigned StatPendBit = 1;
  localparam int unsigned StatDirXBit = 2;
  localparam int unsigned StatDirYBit = 3;

  typedef enum logic [1:0] {StIdle, StPending, StApply, StRun} state_e;

endpackage

// File: rtl/cutter_pan_axis.sv
// One-axis bounce stepper: moves a window edge by step in direction dir and reflects
// at 0 and at Disp-size. i_dir = 0 means increasing, 1 means decreasing.
module cutter_pan_axis #(
  parameter int unsigned Disp   = 1280,
  parameter int unsigned CoordW = 11
) (
  input  logic [CoordW-1:0] i_pos,
  input  logic [CoordW-1:0] i_size,
  input  logic [7:0]        i_step,
  input  logic              i_dir,
  output logic [CoordW-1:0] o_pos,
  output logic              o_dir
);

  // Two guard bits so both overshoot past the limit and undershoot below 0 stay visible
  localparam int unsigned SW = CoordW + 2;
  localparam logic signed [SW-1:0] DispS = SW'(Disp);

  logic signed [SW-1:0] w_pos;
  logic signed [SW-1:0] w_step;
  logic signed [SW-1:0] w_lim;
  logic signed [SW-1:0] w_nx;

  assign w_pos  = $signed({2'b00, i_pos});
  assign w_step = $signed({{(SW-8){1'b0}}, i_step});
  assign w_lim  = DispS - $signed({2'b00, i_size});
  assign w_nx   = i_dir ? (w_pos - w_step) : (w_pos + w_step);

  // Clamp at either edge and flip direction there; a zero step leaves the axis static
  always_comb begin
    o_pos = i_pos;
    o_dir = i_dir;
    if (i_step != 8'd0) begin
      if (w_nx > w_lim) begin
        o_pos = w_lim[CoordW-1:0];
        o_dir = 1'b1;
      end else if (w_nx[SW-1]) begin
        o_pos = '0;
        o_dir = 1'b0;
      end else begin
        o_pos = w_nx[CoordW-1:0];
      end
    end
  end

endmodule

// File: rtl/cutter_ctrl.sv
// Crop-window controller: CPU shadow registers, validated commit at frame start,
// optional auto-pan that bounces the window every PERIOD frames.
module cutter_ctrl
  import cutter_pkg::*;
#(
  parameter int unsigned H_DISP = 1280,
  parameter int unsigned V_DISP = 720,
  parameter int unsigned X_W    = 11,
  parameter int unsigned Y_W    = 11
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_en,
  input  logic [2:0]     wr_addr,
  input  logic [15:0]    wr_data,
  input  logic [2:0]     rd_addr,
  output logic [15:0]    rd_data,
  input  logic           pre_vs,
  output logic           EN,
  output logic [X_W-1:0] START_X,
  output logic [Y_W-1:0] START_Y,
  output logic [X_W-1:0] END_X,
  output logic [Y_W-1:0] END_Y,
  output logic           cfg_err,
  output logic           commit_done
);

  localparam logic [X_W:0]   HLim  = (X_W+1)'(H_DISP);
  localparam logic [Y_W:0]   VLim  = (Y_W+1)'(V_DISP);
  localparam logic [X_W-1:0] HDisp = X_W'(H_DISP);
  localparam logic [Y_W-1:0] VDisp = Y_W'(V_DISP);

  // Shadow (CPU-visible) registers
  logic           r_sh_en, r_sh_pan;
  logic [X_W-1:0] r_sh_sx, r_sh_w;
  logic [Y_W-1:0] r_sh_sy, r_sh_h;
  logic [15:0]    r_sh_step, r_sh_per;

  // Active window and control state
  state_e         r_state;
  logic           r_vs;
  logic [15:0]    r_cnt;
  logic           r_dir_x, r_dir_y;
  logic           r_en;
  logic [X_W-1:0] r_sx, r_ex, r_act_w;
  logic [Y_W-1:0] r_sy, r_ey, r_act_h;
  logic           r_cfg_err, r_done;

  logic           w_vs_rise, w_wr_ctrl, w_commit, w_pan_off, w_err_clr;
  logic [X_W:0]   w_x_sum;
  logic [Y_W:0]   w_y_sum;
  logic           w_valid, w_pan_tick;
  logic [15:0]    w_per_m1;
  logic [X_W-1:0] w_pan_sx;
  logic [Y_W-1:0] w_pan_sy;
  logic           w_pan_dir_x, w_pan_dir_y;

  assign w_vs_rise = pre_vs & ~r_vs;
  assign w_wr_ctrl = wr_en && (wr_addr == AddrCtrl);
  assign w_commit  = w_wr_ctrl & wr_data[CtrlCommitBit];
  assign w_pan_off = w_wr_ctrl & ~wr_data[CtrlAutoPanBit];
  assign w_err_clr = wr_en && (wr_addr == AddrStatus) && wr_data[StatErrBit];

  assign w_x_sum = {1'b0, r_sh_sx} + {1'b0, r_sh_w};
  assign w_y_sum = {1'b0, r_sh_sy} + {1'b0, r_sh_h};
  assign w_valid = (r_sh_w != '0) && (r_sh_h != '0) && (w_x_sum <= HLim) && (w_y_sum <= VLim);

  // PERIOD of 0 behaves like 1
  assign w_per_m1   = (r_sh_per == 16'd0) ? 16'd0 : r_sh_per - 16'd1;
  assign w_pan_tick = (r_cnt >= w_per_m1);

  cutter_pan_axis #(.Disp(H_DISP), .CoordW(X_W)) u_pan_x (
    .i_pos  (r_sx),
    .i_size (r_act_w),
    .i_step (r_sh_step[7:0]),
    .i_dir  (r_dir_x),
    .o_pos  (w_pan_sx),
    .o_dir  (w_pan_dir_x)
  );

  cutter_pan_axis #(.Disp(V_DISP), .CoordW(Y_W)) u_pan_y (
    .i_pos  (r_sy),
    .i_size (r_act_h),
    .i_step (r_sh_step[15:8]),
    .i_dir  (r_dir_y),
    .o_pos  (w_pan_sy),
    .o_dir  (w_pan_dir_y)
  );

  // CPU writes into the shadow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_en   <= 1'b0;
      r_sh_pan  <= 1'b0;
      r_sh_sx   <= '0;
      r_sh_sy   <= '0;
      r_sh_w    <= HDisp;
      r_sh_h    <= VDisp;
      r_sh_step <= '0;
      r_sh_per  <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        AddrCtrl: begin
          r_sh_en  <= wr_data[CtrlEnBit];
          r_sh_pan <= wr_data[CtrlAutoPanBit];
        end
        AddrSx:     r_sh_sx   <= wr_data[X_W-1:0];
        AddrSy:     r_sh_sy   <= wr_data[Y_W-1:0];
        AddrWidth:  r_sh_w    <= wr_data[X_W-1:0];
        AddrHeight: r_sh_h    <= wr_data[Y_W-1:0];
        AddrStep:   r_sh_step <= wr_data;
        AddrPeriod: r_sh_per  <= wr_data;
        default: ;
      endcase
    end
  end

  // Commit/pan FSM with the registered active window, error flag and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_vs      <= 1'b0;
      r_cnt     <= '0;
      r_dir_x   <= 1'b0;
      r_dir_y   <= 1'b0;
      r_en      <= 1'b0;
      r_sx      <= '0;
      r_sy      <= '0;
      r_ex      <= HDisp;
      r_ey      <= VDisp;
      r_act_w   <= HDisp;
      r_act_h   <= VDisp;
      r_cfg_err <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_vs   <= pre_vs;
      r_done <= 1'b0;
      // A failing APPLY below overrides a coincident clear
      if (w_err_clr) r_cfg_err <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_commit) r_state <= StPending;
        end
        StPending: begin
          if (w_vs_rise) r_state <= StApply;
        end
        StApply: begin
          if (w_valid) begin
            r_en    <= r_sh_en;
            r_sx    <= r_sh_sx;
            r_sy    <= r_sh_sy;
            r_ex    <= w_x_sum[X_W-1:0];
            r_ey    <= w_y_sum[Y_W-1:0];
            r_act_w <= r_sh_w;
            r_act_h <= r_sh_h;
            r_cnt   <= '0;
            r_dir_x <= 1'b0;
            r_dir_y <= 1'b0;
            r_done  <= 1'b1;
            r_state <= (r_sh_en && r_sh_pan) ? StRun : StIdle;
          end else begin
            r_cfg_err <= 1'b1;
            r_state   <= StIdle;
          end
        end
        StRun: begin
          if (w_commit) begin
            r_state <= StPending;
          end else if (w_pan_off) begin
            r_state <= StIdle;
          end else if (w_vs_rise) begin
            if (w_pan_tick) begin
              r_cnt   <= '0;
              r_sx    <= w_pan_sx;
              r_sy    <= w_pan_sy;
              r_ex    <= w_pan_sx + r_act_w;
              r_ey    <= w_pan_sy + r_act_h;
              r_dir_x <= w_pan_dir_x;
              r_dir_y <= w_pan_dir_y;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Combinational register read-back; unused bits read 0
  always_comb begin
    rd_data = '0;
    case (rd_addr)
      AddrCtrl: begin
        rd_data[CtrlEnBit]      = r_sh_en;
        rd_data[CtrlAutoPanBit] = r_sh_pan;
      end
      AddrSx:     rd_data[X_W-1:0] = r_sh_sx;
      AddrSy:     rd_data[Y_W-1:0] = r_sh_sy;
      AddrWidth:  rd_data[X_W-1:0] = r_sh_w;
      AddrHeight: rd_data[Y_W-1:0] = r_sh_h;
      AddrStep:   rd_data          = r_sh_step;
      AddrPeriod: rd_data          = r_sh_per;
      default: begin
        rd_data[StatErrBit]  = r_cfg_err;
        rd_data[StatPendBit] = (r_state == StPending) || (r_state == StApply);
        rd_data[StatDirXBit] = r_dir_x;
        rd_data[StatDirYBit] = r_dir_y;
      end
    endcase
  end

  assign EN          = r_en;
  assign START_X     = r_sx;
  assign START_Y     = r_sy;
  assign END_X       = r_ex;
  assign END_Y       = r_ey;
  assign cfg_err     = r_cfg_err;
  assign commit_done = r_done;

endmodule

// File: tb/tb_cutter_ctrl.sv
// Bench for cutter_ctrl: event-level reference model compared every cycle, plus
// hand-computed expectations at the key points of each scenario.
module tb_cutter_ctrl;

  localparam int H = 1280;
  localparam int V = 720;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic        pre_vs;
  logic        EN;
  logic [10:0] START_X, END_X;
  logic [10:0] START_Y, END_Y;
  logic        cfg_err;
  logic        commit_done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  cutter_ctrl #(.H_DISP(H), .V_DISP(V), .X_W(11), .Y_W(11)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .pre_vs      (pre_vs),
    .EN          (EN),
    .START_X     (START_X),
    .START_Y     (START_Y),
    .END_X       (END_X),
    .END_Y       (END_Y),
    .cfg_err     (cfg_err),
    .commit_done (commit_done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // shadow registers
  int m_en, m_pan, m_sx, m_sy, m_w, m_h, m_step, m_per;
  // active window
  int m_a_en, m_a_sx, m_a_sy, m_a_w, m_a_h;
  int m_err, m_done, m_dirx, m_diry, m_cnt;
  bit m_vs, m_pending, m_apply, m_running;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_pan = 0; m_sx = 0; m_sy = 0; m_w = H; m_h = V; m_step = 0; m_per = 0;
    m_a_en = 0; m_a_sx = 0; m_a_sy = 0; m_a_w = H; m_a_h = V;
    m_err = 0; m_done = 0; m_dirx = 0; m_diry = 0; m_cnt = 0;
    m_vs = 0; m_pending = 0; m_apply = 0; m_running = 0;
  endtask

  // Bounce rule for one axis: dir 0 = moving up, 1 = moving down
  task automatic bounce(input int pos, input int dir, input int size, input int step,
                        input int disp, output int npos, output int ndir);
    int t;
    npos = pos;
    ndir = dir;
    if (step != 0) begin
      t = (dir != 0) ? pos - step : pos + step;
      if (t > disp - size) begin
        npos = disp - size;
        ndir = 1;
      end else if (t < 0) begin
        npos = 0;
        ndir = 0;
      end else begin
        npos = t;
      end
    end
  endtask

  function automatic int model_read(input int a);
    case (a)
      0: return m_en | (m_pan << 1);
      1: return m_sx;
      2: return m_sy;
      3: return m_w;
      4: return m_h;
      5: return m_step;
      6: return m_per;
      default: return m_err | (int'(m_pending || m_apply) << 1) | (m_dirx << 2) | (m_diry << 3);
    endcase
  endfunction

  task automatic model_step();
    bit rise, was_apply, set_err, clr, stop;
    int d, per, nx, ny, ndx, ndy;
    rise      = pre_vs && !m_vs;
    m_vs      = pre_vs;
    d         = int'(wr_data);
    m_done    = 0;
    set_err   = 0;
    was_apply = m_apply;
    clr       = wr_en && wr_addr == 3'd7 && wr_data[0];
    stop      = wr_en && wr_addr == 3'd0 && (wr_data[2] || !wr_data[1]);
    if (m_apply) begin
      m_apply = 0;
      if (m_w != 0 && m_h != 0 && m_sx + m_w <= H && m_sy + m_h <= V) begin
        m_a_en = m_en; m_a_sx = m_sx; m_a_sy = m_sy; m_a_w = m_w; m_a_h = m_h;
        m_done = 1; m_cnt = 0; m_dirx = 0; m_diry = 0;
        m_running = (m_en != 0) && (m_pan != 0);
      end else begin
        set_err = 1;
        m_running = 0;
      end
    end else if (m_pending) begin
      if (rise) begin
        m_pending = 0;
        m_apply = 1;
      end
    end else if (m_running && rise && !stop) begin
      per = (m_per == 0) ? 1 : m_per;
      if (m_cnt + 1 >= per) begin
        m_cnt = 0;
        bounce(m_a_sx, m_dirx, m_a_w, m_step % 256, H, nx, ndx);
        bounce(m_a_sy, m_diry, m_a_h, m_step / 256, V, ny, ndy);
        m_a_sx = nx; m_dirx = ndx; m_a_sy = ny; m_diry = ndy;
        m_done = 1;
      end else begin
        m_cnt++;
      end
    end
    if (wr_en) begin
      case (wr_addr)
        3'd0: begin
          m_en = d % 2; m_pan = (d / 2) % 2;
          if (!was_apply) begin
            if (wr_data[2]) begin
              m_pending = 1;
              m_running = 0;
            end else if (!wr_data[1]) begin
              m_running = 0;
            end
          end
        end
        3'd1: m_sx = d % 2048;
        3'd2: m_sy = d % 2048;
        3'd3: m_w = d % 2048;
        3'd4: m_h = d % 2048;
        3'd5: m_step = d;
        3'd6: m_per = d;
        default: ;
      endcase
    end
    if (set_err) m_err = 1;
    else if (clr) m_err = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    check("EN", int'(EN), m_a_en);
    check("START_X", int'(START_X), m_a_sx);
    check("START_Y", int'(START_Y), m_a_sy);
    check("END_X", int'(END_X), m_a_sx + m_a_w);
    check("END_Y", int'(END_Y), m_a_sy + m_a_h);
    check("cfg_err", int'(cfg_err), m_err);
    check("commit_done", int'(commit_done), m_done);
    check("rd_data", int'(rd_data), model_read(int'(rd_addr)));
  end

  always @(negedge clk) if (commit_done === 1'b1) done_cnt++;

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
    rd_addr = rd_addr + 3'd1;
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1;
    wr_addr = a[2:0];
    wr_data = d[15:0];
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic frame();
    pre_vs = 1'b1;
    repeat (3) cyc();
    pre_vs = 1'b0;
    repeat (6) cyc();
  endtask

  task automatic read_check(input string name, input int a, input int exp);
    rd_addr = a[2:0];
    #1;
    check(name, int'(rd_data), exp);
  endtask

  int d0;

  initial begin
    model_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; pre_vs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) cyc();

    // Reset state
    check("rst_EN", int'(EN), 0);
    check("rst_START_X", int'(START_X), 0);
    check("rst_END_X", int'(END_X), 1280);
    check("rst_END_Y", int'(END_Y), 720);
    read_check("rst_STATUS", 7, 0);
    read_check("rst_WIDTH", 3, 1280);

    // Basic commit
    wr(1, 100); wr(2, 50); wr(3, 640); wr(4, 360); wr(0, 5);
    repeat (4) cyc();
    check("pre_commit_START_X", int'(START_X), 0);
    d0 = done_cnt;
    frame();
    check("c1_START_X", int'(START_X), 100);
    check("c1_END_X", int'(END_X), 740);
    check("c1_START_Y", int'(START_Y), 50);
    check("c1_END_Y", int'(END_Y), 410);
    check("c1_EN", int'(EN), 1);
    check("c1_done_pulses", done_cnt - d0, 1);

    // COMMIT coincident with vs rise while idle waits for the next frame
    wr(1, 200);
    pre_vs = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'd5;
    cyc();
    wr_en = 1'b0;
    repeat (2) cyc();
    pre_vs = 1'b0;
    repeat (6) cyc();
    check("coinc_START_X", int'(START_X), 100);
    frame();
    check("coinc_next_START_X", int'(START_X), 200);
    check("coinc_next_END_X", int'(END_X), 840);

    // Rejected commit: 700+640 > 1280
    wr(1, 700); wr(0, 5);
    frame();
    check("bad_START_X", int'(START_X), 200);
    check("bad_cfg_err", int'(cfg_err), 1);
    read_check("bad_STATUS", 7, 1);
    wr(7, 1);
    check("clr_cfg_err", int'(cfg_err), 0);

    // STATUS clear in the same cycle as a failing APPLY leaves the error set
    wr(0, 5);
    pre_vs = 1'b1;
    cyc();
    wr(7, 1);
    cyc();
    pre_vs = 1'b0;
    repeat (4) cyc();
    check("clr_vs_apply_cfg_err", int'(cfg_err), 1);
    wr(7, 1);

    // Auto-pan, PERIOD=1, dx=20 bouncing at the right edge
    wr(1, 1200); wr(3, 64); wr(5, 20); wr(6, 1); wr(0, 7);
    frame();
    check("pan0_START_X", int'(START_X), 1200);
    frame();
    check("pan1_START_X", int'(START_X), 1216);
    check("pan1_END_X", int'(END_X), 1280);
    read_check("pan1_STATUS", 7, 4);
    frame();
    check("pan2_START_X", int'(START_X), 1196);
    frame();
    check("pan3_START_X", int'(START_X), 1176);

    // PERIOD=3, dx=10, dy=30: one step every third frame
    wr(5, (30 << 8) | 10); wr(6, 3);
    frame();
    check("p3a_START_X", int'(START_X), 1176);
    frame();
    check("p3b_START_X", int'(START_X), 1176);
    check("p3b_START_Y", int'(START_Y), 50);
    frame();
    check("p3c_START_X", int'(START_X), 1166);
    check("p3c_START_Y", int'(START_Y), 80);
    check("p3c_END_Y", int'(END_Y), 440);

    // Leaving auto-pan keeps the window where it is
    wr(0, 1);
    repeat (3) frame();
    check("stop_START_X", int'(START_X), 1166);
    read_check("stop_CTRL", 0, 1);

    // Re-enter RUN, then reset mid-frame
    wr(0, 7);
    frame();
    check("rerun_START_X", int'(START_X), 1200);
    pre_vs = 1'b1;
    cyc();
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_EN", int'(EN), 0);
    check("async_START_X", int'(START_X), 0);
    check("async_START_Y", int'(START_Y), 0);
    check("async_END_X", int'(END_X), 1280);
    check("async_END_Y", int'(END_Y), 720);
    check("async_done", int'(commit_done), 0);
    repeat (2) cyc();
    pre_vs = 1'b0;
    rst_n = 1'b1;
    repeat (2) cyc();
    d0 = done_cnt;
    frame();
    frame();
    check("post_rst_START_X", int'(START_X), 0);
    check("post_rst_EN", int'(EN), 0);
    check("post_rst_done_pulses", done_cnt - d0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cutter_ctrl.md
Name: cutter_ctrl

Overview:
- Register-programmed controller for the video crop stage; produces the crop stage's EN, START_X/Y and END_X/Y.
- Holds shadow registers written by the CPU bus and validates them.
- Commits them atomically at a frame boundary (rising edge of pre_vs), so a window never changes mid-frame.
- Optional auto-pan mode slides the window across the frame, bouncing at the edges, every PERIOD frames.

Parameters:
- H_DISP, 1280, horizontal frame size in pixels
- V_DISP, 720, vertical frame size in lines
- X_W, 11, width of X coordinates
- Y_W, 11, width of Y coordinates

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset; asynchronous, active-low; clock clk
- wr_en  in  1  register write strobe, one cycle
- wr_addr  in  3  write register index
- wr_data  in  16  write data
- rd_addr  in  3  read register index
- rd_data  out  16  combinational read-back of rd_addr
- pre_vs  in  1  frame sync from video source, active high
- EN  out  1  crop enable (active copy)
- START_X  out  X_W  active window left edge
- START_Y  out  Y_W  active window top edge
- END_X  out  X_W  active exclusive right edge = start_x+width
- END_Y  out  Y_W  active exclusive bottom edge
- cfg_err  out  1  sticky: last commit rejected
- commit_done  out  1  one-cycle pulse when a commit or pan step updates the outputs

Behaviour:
- Register map, 16-bit; reads of unused bits return 0:
  - 0 CTRL: [0] EN, [1] AUTO_PAN, [2] COMMIT (write-1 self-clearing, reads 0)
  - 1 SX
  - 2 SY
  - 3 WIDTH
  - 4 HEIGHT
  - 5 STEP: [7:0] dx, [15:8] dy
  - 6 PERIOD: frames per pan step, 0 is treated as 1
  - 7 STATUS: [0] cfg_err (write 1 clears), [1] pending (RO), [2] dir_x (RO), [3] dir_y (RO)
- Reset values:
  - All shadow registers 0, except WIDTH=H_DISP and HEIGHT=V_DISP.
  - Active EN=0, START_X=0, START_Y=0, END_X=H_DISP, END_Y=V_DISP.
  - cfg_err=0, commit_done=0, pan directions +1, frame counter 0, state IDLE.
- Frame edge: vs_r is pre_vs registered; vs_rise = pre_vs & ~vs_r.
- FSM:
  - IDLE: COMMIT write -> PENDING.
  - PENDING: vs_rise -> APPLY.
  - APPLY (1 cycle):
    - Validate: WIDTH!=0, HEIGHT!=0, SX+WIDTH<=H_DISP, SY+HEIGHT<=V_DISP. Sums are computed at X_W+1 / Y_W+1 bits, with no overflow.
    - Valid: load active registers, pulse commit_done, frame counter=0, directions=+1.
    - Invalid: keep previous active registers, set cfg_err, no commit_done.
    - Next state: RUN if EN & AUTO_PAN were committed, else IDLE.
  - RUN: on each vs_rise, the frame counter increments; when it reaches max(PERIOD,1)-1, it resets and one pan step applies in the same cycle (commit_done pulses).
  - RUN exits: COMMIT write -> PENDING (the pan stops; the new config is taken at the next frame). CTRL write with AUTO_PAN=0 -> IDLE; the active window stays at its current position.
- Output latency: commit/pan outputs update on the clk edge after the vs_rise cycle, i.e. 2 clk after pre_vs rises. The crop stage holds its counters in reset while pre_vs is high, so the update is glitch-free.
- Pan step in X (Y is identical with dy, V_DISP and HEIGHT):
  - nx = sx ± dx, computed signed at X_W+2 bits.
  - If nx > H_DISP-width: sx = H_DISP-width and dir_x flips to -.
  - If nx < 0: sx = 0 and dir_x flips to +.
  - dx=0 leaves the axis static.
  - END_X tracks sx+width.
- Simultaneous events:
  - A COMMIT write in the same cycle as vs_rise while IDLE takes effect at the next vs_rise, not this one.
  - A register write in the APPLY cycle updates the shadow register only; validation uses values sampled before the write.
  - A STATUS clear coincident with a failing APPLY leaves cfg_err=1.
- Asynchronous reset mid-frame returns every output to its reset value immediately.

Decomposition:
- Shared package cutter_pkg holds:
  - register address constants (CTRL..STATUS) and CTRL/STATUS bit indices
  - the FSM state enum (IDLE, PENDING, APPLY, RUN)
- A natural sub-module is cutter_pan_axis: one bounce-stepper per axis, parameterised by DISP size and coordinate width. It takes pos, size, step and dir, and returns next pos and next dir. It is instantiated twice.

Test Plan:
- Reset, no writes -> EN=0, START_X=0, END_X=1280, END_Y=720, rd_data@7=0.
- Write SX=100, SY=50, WIDTH=640, HEIGHT=360, CTRL=0x5, then pulse pre_vs -> 2 clk after its rise START_X=100, END_X=740, START_Y=50, END_Y=410, EN=1, commit_done single pulse. Outputs are unchanged before the pulse.
- Write SX=700, WIDTH=640, COMMIT, pulse pre_vs -> outputs unchanged, cfg_err=1, STATUS[0]=1. Write STATUS=1 -> cfg_err=0.
- Commit SX=1200, WIDTH=64, dx=20, PERIOD=1, AUTO_PAN+EN -> per frame START_X 1200, 1216 (clamped, dir_x=-), 1196, 1176.
- PERIOD=3, dx=10 in RUN -> START_X changes only on every 3rd vs rise.
- Assert rst_n low while in RUN mid-frame -> outputs at reset values immediately. After release, no update until a new COMMIT and vs.
